bcd_arbiter: RTL and testbench

BCD_ARBITER -- requirements
Module: bcd_arbiter

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_arbiter_binparabcd.sv | 59 +++++
 rtl/bcd_arbiter.sv | 149 ++++++++++++++
 tb/tb_bcd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the round-robin BCD conversion arbiter.
// Holds the arbiter FSM states, operand/result widths and the watchdog default.
package bcd_pkg;

    localparam int BIN_W       = 8;
    localparam int BCD_W       = 12;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    // Double-dabble digit correction applied before each shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_arbiter_binparabcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble, 1 bit/cycle).
// Ports: clk, rst (async high), start, bin in; ready, done_tick (pulse), bcd out.
module binparabcd
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done_tick,
    output logic [BCD_W-1:0] bcd
);

    localparam int SH_W = BCD_W + BIN_W;
    localparam logic [2:0] LAST = 3'(BIN_W - 1);

    logic            run;
    logic [2:0]      cnt;
    logic [SH_W-1:0] sh;
    logic [SH_W-1:0] adj;
    logic [SH_W-1:0] sh_nx;

    always_comb begin
        adj = {dd_adj(sh[BIN_W+8 +: 4]),
               dd_adj(sh[BIN_W+4 +: 4]),
               dd_adj(sh[BIN_W +: 4]),
               sh[BIN_W-1:0]};
        sh_nx = adj << 1;
    end

    assign ready = ~run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
            done_tick <= 1'b0;
            bcd       <= '0;
        end else begin
            done_tick <= 1'b0;
            if (!run && start) begin
                sh  <= {{BCD_W{1'b0}}, bin};
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                sh  <= sh_nx;
                cnt <= cnt + 3'd1;
                if (cnt == LAST) begin
                    run       <= 1'b0;
                    done_tick <= 1'b1;
                    bcd       <= sh_nx[SH_W-1:BIN_W];
                end
            end
        end
    end

endmodule

// File: rtl/bcd_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ clients.
// Ports: clk, rst, req, bin in; gnt, busy, done, done_id, bcd, err out.
module bcd_arbiter
    import bcd_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*BIN_W-1:0]   bin,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [BCD_W-1:0]         bcd,
    output logic                     err
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    state_t state;
    state_t state_nx;

    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic             grant_ok;
    logic [BIN_W-1:0] opnd;
    logic [WD_W-1:0]  wd;
    logic [BCD_W-1:0] bcd_r;
    logic             done_r;
    logic [ID_W-1:0]  done_id_r;

    logic             c_start;
    logic             c_ready;
    logic             c_done;
    logic [BCD_W-1:0] c_bcd;

    binparabcd u_conv (
        .clk       (clk),
        .rst       (rst),
        .start     (c_start),
        .bin       (opnd),
        .ready     (c_ready),
        .done_tick (c_done),
        .bcd       (c_bcd)
    );

    // First requester strictly after the last one served, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(last) + k) % N_REQ);
            end
        end
    end

    // The cycle done is high counts as a guard cycle: no grant alongside it.
    assign grant_ok = (state == IDLE) && !rst && !done_r
                      && c_ready && found;

    always_comb begin
        state_nx = state;
        c_start  = 1'b0;
        gnt      = '0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    gnt      = N_REQ'(1) << pick;
                    state_nx = START;
                end
            end
            START: begin
                c_start  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (c_done) begin
                    state_nx = OUT;
                end else if (wd == WD_MAX) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end
            end
            OUT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LAST_RST;
            idx       <= '0;
            opnd      <= '0;
            wd        <= '0;
            bcd_r     <= '0;
            done_r    <= 1'b0;
            done_id_r <= '0;
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        idx  <= pick;
                        opnd <= bin[int'(pick)*BIN_W +: BIN_W];
                    end
                end
                START: begin
                    wd <= '0;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (c_done) begin
                        bcd_r <= c_bcd;
                    end
                end
                OUT: begin
                    done_r    <= 1'b1;
                    done_id_r <= idx;
                    last      <= idx;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = done_r;
    assign done_id = done_id_r;
    assign bcd     = bcd_r;

endmodule

// File: tb/tb_bcd_arbiter.sv
// Scoreboard bench for bcd_arbiter: directed vectors, expected results queued.
// A second instance with a short watchdog exercises the timeout path.
module tb_bcd_arbiter;
    import bcd_pkg::*;

    localparam int T1 = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [3:0]  req0, req1;
    logic [31:0] bin0, bin1;
    logic [3:0]  gnt0, gnt1;
    logic        busy0, busy1, done0, done1, err0, err1;
    logic [1:0]  done_id0, done_id1;
    logic [11:0] bcd0, bcd1;

    bcd_arbiter #(.N_REQ(4)) u0 (
        .clk(clk), .rst(rst0), .req(req0), .bin(bin0), .gnt(gnt0),
        .busy(busy0), .done(done0), .done_id(done_id0), .bcd(bcd0),
        .err(err0)
    );

    bcd_arbiter #(.N_REQ(4), .TIMEOUT(T1)) u1 (
        .clk(clk), .rst(rst1), .req(req1), .bin(bin1), .gnt(gnt1),
        .busy(busy1), .done(done1), .done_id(done_id1), .bcd(bcd1),
        .err(err1)
    );

    typedef struct {
        logic [1:0]  id;
        logic [11:0] bcd;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_ids[$];
    int   gnt_cyc[$];
    int   done_cyc[$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc;
    int   gnt1_cyc, err1_cyc, done1_cnt;
    logic busy1_post;
    logic [3:0] hold0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [11:0] b);
        exp_t e;
        e.id  = id;
        e.bcd = b;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst0 && done0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: id=%0d bcd=%0h, expected none",
                         done_id0, bcd0);
            end else begin
                e = exp_q.pop_front();
                check("done_id", 32'(done_id0), 32'(e.id));
                check("done_bcd", 32'(bcd0), 32'(e.bcd));
            end
        end
    end

    // Protocol invariants on both instances.
    always @(negedge clk) begin
        check("gnt0_onehot0", 32'($onehot0(gnt0)), 32'd1);
        check("gnt1_onehot0", 32'($onehot0(gnt1)), 32'd1);
        check("done0_err0_excl", 32'(done0 & err0), 32'd0);
        check("done1_err1_excl", 32'(done1 & err1), 32'd0);
    end

    // One clock: sample at negedge, then retire granted requests.
    task automatic step();
        logic [3:0] g0, g1;
        @(negedge clk);
        cyc++;
        g0 = gnt0;
        g1 = gnt1;
        for (int i = 0; i < 4; i++) begin
            if (g0[i]) begin
                gnt_ids.push_back(i);
                gnt_cyc.push_back(cyc);
            end
        end
        if (done0) done_cyc.push_back(cyc);
        if (g1 != 4'd0) gnt1_cyc = cyc;
        if (cyc == err1_cyc + 1) busy1_post = busy1;
        if (err1) err1_cyc = cyc;
        if (done1) done1_cnt++;
        @(posedge clk);
        #1;
        req0 = req0 & ~(g0 & ~hold0);
        req1 = req1 & ~g1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (((req0 & ~hold0) != 4'd0 || busy0 || exp_q.size() != 0)
               && k < 400) begin
            step();
            k++;
        end
        if (k >= 400) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", k);
        end
    endtask

    task automatic wait_grants(input int n);
        int k;
        k = 0;
        while (gnt_ids.size() < n && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_grants: %0d grants, expected %0d",
                     gnt_ids.size(), n);
        end
    endtask

    task automatic clear_logs();
        gnt_ids.delete();
        gnt_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt0), 32'd0);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_err"}, 32'(err0), 32'd0);
        check({tag, "_bcd"}, 32'(bcd0), 32'd0);
        check({tag, "_done_id"}, 32'(done_id0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        req0 = '0;
        req1 = '0;
        bin0 = '0;
        bin1 = '0;
        hold0 = '0;
        cyc = 0;
        gnt1_cyc = -100;
        err1_cyc = -100;
        done1_cnt = 0;
        busy1_post = 1'b1;

        // Reset holds everything quiet even with all requests up.
        repeat (2) @(posedge clk);
        #1;
        bin0 = {8'd255, 8'd200, 8'd9, 8'd0};
        req0 = 4'b1111;
        @(negedge clk);
        check_zero("reset");
        push(2'd0, 12'h000);
        push(2'd1, 12'h009);
        push(2'd2, 12'h200);
        push(2'd3, 12'h255);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // All four requesting: strict order 0,1,2,3.
        wait_idle();
        check("rr4_count", 32'(gnt_ids.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr4_order", 32'(gnt_ids[i]), 32'(i));

        // Single request from requester 0.
        clear_logs();
        bin0[7:0] = 8'd54;
        req0 = 4'b0001;
        push(2'd0, 12'h054);
        wait_idle();
        check("single_count", 32'(gnt_ids.size()), 32'd1);
        check("single_id", 32'(gnt_ids[0]), 32'd0);

        // Persistent requester re-granted the cycle after done.
        clear_logs();
        bin0[15:8] = 8'd123;
        hold0 = 4'b0010;
        req0 = 4'b0010;
        push(2'd1, 12'h123);
        push(2'd1, 12'h123);
        wait_grants(2);
        hold0 = '0;
        req0[1] = 1'b0;
        wait_idle();
        check("regrant_gap", 32'(gnt_cyc[1]), 32'(done_cyc[0] + 1));

        // Held req[2] with req[0] arriving mid-service: 2,0,2.
        clear_logs();
        bin0[23:16] = 8'd77;
        bin0[7:0] = 8'd3;
        hold0 = 4'b0100;
        req0 = 4'b0100;
        push(2'd2, 12'h077);
        push(2'd0, 12'h003);
        push(2'd2, 12'h077);
        wait_grants(1);
        repeat (3) step();
        req0[0] = 1'b1;
        wait_grants(3);
        hold0 = '0;
        req0[2] = 1'b0;
        wait_idle();
        check("alt_count", 32'(gnt_ids.size()), 32'd3);
        check("alt_0", 32'(gnt_ids[0]), 32'd2);
        check("alt_1", 32'(gnt_ids[1]), 32'd0);
        check("alt_2", 32'(gnt_ids[2]), 32'd2);

        // Reset during WAIT discards the conversion.
        clear_logs();
        bin0[7:0] = 8'd99;
        req0 = 4'b0001;
        wait_grants(1);
        repeat (5) step();
        rst0 = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        repeat (20) step();
        check("midrst_no_done", 32'(done_cyc.size()), 32'd0);

        // Normal service after reset; a short-lived req[1] is dropped.
        clear_logs();
        bin0[31:24] = 8'd150;
        req0 = 4'b1000;
        push(2'd3, 12'h150);
        wait_grants(1);
        req0[1] = 1'b1;
        repeat (3) step();
        req0[1] = 1'b0;
        wait_idle();
        check("post_rst_count", 32'(gnt_ids.size()), 32'd1);
        check("post_rst_id", 32'(gnt_ids[0]), 32'd3);

        // Watchdog expiry on the short-timeout instance.
        bin1[7:0] = 8'd42;
        req1 = 4'b0001;
        for (int k = 0; k < 60; k++) step();
        check("to_err_cycle", 32'(err1_cyc), 32'(gnt1_cyc + 1 + T1));
        check("to_busy_after", 32'(busy1_post), 32'd0);
        check("to_bcd_kept", 32'(bcd1), 32'd0);
        check("to_no_done", 32'(done1_cnt), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
